// File: rtl/spi_cmd_sequencer.sv
// Turns SPI chip-select frames into register-file read/write strobes and returns read data.
// Define SPI_CMD_AUTOINC_EN for burst frames with automatic address advance.
module spi_cmd_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_active,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic [7:0] tx_byte,
    output logic       tx_load,
    output logic       read,
    output logic       write,
    output logic [5:0] addr,
    output logic [7:0] data_write,
    input  logic [7:0] data_read,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        RD_ISSUE,
        RD_RET,
        TAIL
    } state_t;

    state_t state;

`ifdef SPI_CMD_AUTOINC_EN
    logic frame_wr;

    // Low byte steps to high byte; high byte steps to the next register's low byte.
    function automatic logic [5:0] addr_advance(input logic [5:0] a);
        logic [4:0] idx;
        idx = a[4:0] + 5'd1;
        return a[5] ? {1'b0, idx} : {1'b1, a[4:0]};
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            read       <= 1'b0;
            write      <= 1'b0;
            tx_load    <= 1'b0;
            busy       <= 1'b0;
            addr       <= 6'h00;
            data_write <= 8'h00;
            tx_byte    <= 8'h00;
`ifdef SPI_CMD_AUTOINC_EN
            frame_wr   <= 1'b0;
`endif
        end else begin
            read    <= 1'b0;
            write   <= 1'b0;
            tx_load <= 1'b0;
            if (!frame_active) begin
                // Frame end always wins; pending strobes already on the outputs finish this cycle.
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_valid) begin
                            addr <= {rx_byte[6], rx_byte[4:0]};
                            busy <= 1'b1;
`ifdef SPI_CMD_AUTOINC_EN
                            frame_wr <= rx_byte[7];
`endif
                            if (rx_byte[7]) begin
                                state <= WR_DATA;
                            end else begin
                                read  <= 1'b1;
                                state <= RD_ISSUE;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (rx_valid) begin
                            data_write <= rx_byte;
                            write      <= 1'b1;
                            state      <= TAIL;
                        end
                    end
                    RD_ISSUE: begin
                        tx_byte <= data_read;
                        tx_load <= 1'b1;
                        state   <= RD_RET;
                    end
                    RD_RET: begin
                        state <= TAIL;
                    end
                    TAIL: begin
`ifdef SPI_CMD_AUTOINC_EN
                        if (rx_valid) begin
                            addr <= addr_advance(addr);
                            if (frame_wr) begin
                                data_write <= rx_byte;
                                write      <= 1'b1;
                            end else begin
                                read  <= 1'b1;
                                state <= RD_ISSUE;
                            end
                        end
`else
                        state <= TAIL;
`endif
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Bench for spi_cmd_sequencer: frame-level reference model, per-cycle compare, directed and random frames.
// Honours SPI_CMD_AUTOINC_EN the same way as the design.
module tb_spi_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_active = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic       read;
    logic       write;
    logic [5:0] addr;
    logic [7:0] data_write;
    logic [7:0] data_read;
    logic       busy;

    always #5 clk = ~clk;

    spi_cmd_sequencer dut (
        .clk(clk), .rst_n(rst_n), .frame_active(frame_active),
        .rx_valid(rx_valid), .rx_byte(rx_byte),
        .tx_byte(tx_byte), .tx_load(tx_load),
        .read(read), .write(write), .addr(addr),
        .data_write(data_write), .data_read(data_read), .busy(busy)
    );

    // Register file stand-in: unwritten locations return a fixed address-derived pattern.
    function automatic logic [7:0] seed(input int a);
        return 8'(a * 37 + 90);
    endfunction

    logic [7:0] mem [64];
    bit         seen [64];
    assign data_read = seen[addr] ? mem[addr] : seed(int'(addr));
    always @(posedge clk) begin
        if (write) begin
            mem[addr]  <= data_write;
            seen[addr] <= 1'b1;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: tracks bytes accepted in the current frame.
    bit         m_read = 0, m_write = 0, m_load = 0, m_busy = 0;
    logic [5:0] m_addr = 6'h00;
    logic [7:0] m_dw = 8'h00, m_tx = 8'h00;
    logic [7:0] mm [64];
    bit         mseen [64];
    int         nb = 0;
    bit         is_wr = 0;
    bit         n_read, n_write, n_load, n_busy;
    logic [5:0] n_addr;
    logic [7:0] n_dw, n_tx;
    bit         fa_s, rv_s;
    logic [7:0] b_s;

`ifdef SPI_CMD_AUTOINC_EN
    // Treat {index, hl} as one linear 6-bit counter.
    function automatic logic [5:0] adv(input logic [5:0] a);
        int lin;
        lin = (int'(a[4:0]) * 2 + int'(a[5]) + 1) % 64;
        return {lin[0], lin[5:1]};
    endfunction
`endif

    always @(posedge clk) begin
        fa_s = frame_active;
        rv_s = rx_valid;
        b_s  = rx_byte;
        if (!rst_n) begin
            m_read = 0; m_write = 0; m_load = 0; m_busy = 0;
            m_addr = 6'h00; m_dw = 8'h00; m_tx = 8'h00;
            nb = 0; is_wr = 0;
        end else begin
            if (m_write) begin
                mm[m_addr]    = m_dw;
                mseen[m_addr] = 1'b1;
            end
            n_read = 0; n_write = 0; n_load = 0;
            n_addr = m_addr; n_dw = m_dw; n_tx = m_tx; n_busy = m_busy;
            if (!fa_s) begin
                n_busy = 0;
                nb = 0;
            end else begin
                if (m_read) begin
                    n_load = 1;
                    n_tx = mseen[m_addr] ? mm[m_addr] : seed(int'(m_addr));
                end
                if (rv_s && !m_read && !m_load) begin
                    if (nb == 0) begin
                        is_wr  = b_s[7];
                        n_addr = {b_s[6], b_s[4:0]};
                        n_busy = 1;
                        n_read = !b_s[7];
                    end else if (is_wr && nb == 1) begin
                        n_write = 1;
                        n_dw = b_s;
                    end
`ifdef SPI_CMD_AUTOINC_EN
                    else begin
                        n_addr = adv(m_addr);
                        if (is_wr) begin
                            n_write = 1;
                            n_dw = b_s;
                        end else begin
                            n_read = 1;
                        end
                    end
`endif
                    nb++;
                end
            end
            m_read = n_read; m_write = n_write; m_load = n_load; m_busy = n_busy;
            m_addr = n_addr; m_dw = n_dw; m_tx = n_tx;
        end
        #1;
        check("m_read", 32'(read), 32'(m_read));
        check("m_write", 32'(write), 32'(m_write));
        check("m_tx_load", 32'(tx_load), 32'(m_load));
        check("m_busy", 32'(busy), 32'(m_busy));
        check("m_addr", 32'(addr), 32'(m_addr));
        check("m_data_write", 32'(data_write), 32'(m_dw));
        check("m_tx_byte", 32'(tx_byte), 32'(m_tx));
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic frame_on();
        @(negedge clk);
        frame_active = 1'b1;
    endtask

    task automatic frame_off();
        @(negedge clk);
        frame_active = 1'b0;
        @(negedge clk);
    endtask

    int nbytes;

    initial begin
        idle(3);
        check("rst_read", 32'(read), 0);
        check("rst_write", 32'(write), 0);
        check("rst_tx_load", 32'(tx_load), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_addr", 32'(addr), 0);
        check("rst_data_write", 32'(data_write), 0);
        check("rst_tx_byte", 32'(tx_byte), 0);
        rst_n = 1'b1;
        idle(2);

        // Write low byte
        frame_on();
        send_byte(8'h80);
        idle(1);
        send_byte(8'h34);
        check("wr_lo_write", 32'(write), 1);
        check("wr_lo_addr", 32'(addr), 32'h00);
        check("wr_lo_data", 32'(data_write), 32'h34);
        idle(1);
        check("wr_lo_one_cycle", 32'(write), 0);
        frame_off();

        // Store 0xBE at 0x28, then read it back
        frame_on();
        send_byte(8'hC8);
        idle(1);
        send_byte(8'hBE);
        check("wr_hi_addr", 32'(addr), 32'h28);
        frame_off();
        frame_on();
        send_byte(8'h48);
        check("rd_read", 32'(read), 1);
        check("rd_addr", 32'(addr), 32'h28);
        idle(1);
        check("rd_tx_load", 32'(tx_load), 1);
        check("rd_tx_byte", 32'(tx_byte), 32'hBE);
        idle(1);
        check("rd_tx_load_done", 32'(tx_load), 0);
        check("rd_tx_hold", 32'(tx_byte), 32'hBE);
        frame_off();

        // Abort before data byte
        frame_on();
        send_byte(8'h83);
        check("abort_busy_up", 32'(busy), 1);
        idle(1);
        @(negedge clk);
        frame_active = 1'b0;
        @(negedge clk);
        check("abort_busy_down", 32'(busy), 0);
        check("abort_no_write", 32'(write), 0);
        frame_on();
        send_byte(8'h8A);
        idle(1);
        send_byte(8'h05);
        check("after_abort_write", 32'(write), 1);
        check("after_abort_addr", 32'(addr), 32'h0A);
        check("after_abort_data", 32'(data_write), 32'h05);
        frame_off();

        // Burst frame
        frame_on();
        send_byte(8'h9F);
        idle(1);
        send_byte(8'h11);
        check("burst1_write", 32'(write), 1);
        check("burst1_addr", 32'(addr), 32'h1F);
        check("burst1_data", 32'(data_write), 32'h11);
        idle(1);
        send_byte(8'h22);
`ifdef SPI_CMD_AUTOINC_EN
        check("burst2_write", 32'(write), 1);
        check("burst2_addr", 32'(addr), 32'h3F);
        check("burst2_data", 32'(data_write), 32'h22);
`else
        check("burst2_write", 32'(write), 0);
        check("burst2_addr", 32'(addr), 32'h1F);
`endif
        idle(1);
        send_byte(8'h33);
`ifdef SPI_CMD_AUTOINC_EN
        check("burst3_write", 32'(write), 1);
        check("burst3_addr", 32'(addr), 32'h00);
        check("burst3_data", 32'(data_write), 32'h33);
`else
        check("burst3_write", 32'(write), 0);
        check("burst3_data", 32'(data_write), 32'h11);
`endif
        frame_off();

        // Async reset while waiting for write data
        frame_on();
        send_byte(8'h85);
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_addr", 32'(addr), 0);
        check("arst_write", 32'(write), 0);
        check("arst_data", 32'(data_write), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h07);
        check("arst_instr_read", 32'(read), 1);
        check("arst_instr_addr", 32'(addr), 32'h07);
        idle(3);
        frame_off();

        // Byte with chip select inactive
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = 8'h80;
        @(negedge clk);
        rx_valid = 1'b0;
        check("ign_busy", 32'(busy), 0);
        check("ign_read", 32'(read), 0);
        idle(2);
        check("ign_write", 32'(write), 0);

        // Random frames
        for (int f = 0; f < 300; f++) begin
            @(negedge clk);
            frame_active = 1'b1;
            idle($urandom_range(0, 2));
            nbytes = $urandom_range(0, 5);
            for (int k = 0; k < nbytes; k++) begin
                @(negedge clk);
                rx_valid = 1'b1;
                rx_byte  = 8'($urandom);
                @(negedge clk);
                rx_valid = 1'b0;
                idle($urandom_range(0, 4));
            end
            @(negedge clk);
            frame_active = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                rx_valid = 1'b1;
                rx_byte  = 8'($urandom);
            end
            @(negedge clk);
            rx_valid = 1'b0;
            idle($urandom_range(0, 2));
        end

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
